// File: rtl/multicycle_mips_if.sv
// Bus bundle between the multicycle MIPS core (master) and its instruction ROM / data SRAM (slave).
interface multicycle_mips_if #(
   parameter int unsigned DATA_AW = 7
) ();
   logic [31:0]        IR_addr;
   logic               IR_req;
   logic [31:0]        IR;
   logic               IR_valid;
   logic               CEN;
   logic               WEN;
   logic               OEN;
   logic [DATA_AW-1:0] A;
   logic [31:0]        ReadData2;
   logic [31:0]        ReadDataMem;
   logic               mem_ready;
   logic [31:0]        RF_writedata;
   logic               RF_we;
   logic               trap;

   modport master (
      output IR_addr, IR_req, CEN, WEN, OEN, A, ReadData2, RF_writedata, RF_we, trap,
      input  IR, IR_valid, ReadDataMem, mem_ready
   );

   modport slave (
      input  IR_addr, IR_req, CEN, WEN, OEN, A, ReadData2, RF_writedata, RF_we, trap,
      output IR, IR_valid, ReadDataMem, mem_ready
   );
endinterface

// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS core with valid/ready stalls on both memory ports and a trap on unsupported opcodes.
// Optional feature macro: MULTICYCLE_ADDI_EN adds addi (opcode 0x08).
module multicycle_mips #(
   parameter int unsigned DATA_AW  = 7,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic               clk,
   input logic               rst_n,
   multicycle_mips_if.master bus
);
   localparam int unsigned NREG   = 32;
   localparam logic [4:0]  RA_IDX = 5'd31;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
`ifdef MULTICYCLE_ADDI_EN
   localparam logic [5:0] OP_ADDI  = 6'h08;
`endif
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_JR    = 6'h08;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   state_e             state_q;
   logic [31:0]        pc_q;
   logic [31:0]        ir_q;
   logic [31:0]        opa_q;
   logic [31:0]        opb_q;
   logic [31:0]        br_tgt_q;
   logic [31:0]        res_q;
   logic [31:0]        mdr_q;
   logic [31:0]        rf_q [NREG];
   logic               ir_req_q;
   logic               cen_q;
   logic               wen_q;
   logic [DATA_AW-1:0] a_q;
   logic [31:0]        rd2_q;
   logic [31:0]        rf_wdata_q;
   logic               rf_we_q;
   logic               trap_q;

   // Instruction fields, decoded from the latched IR in every state
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] sext_imm;
   logic [31:0] pc_plus4;
   logic [31:0] jmp_tgt;

   assign op       = ir_q[31:26];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign funct    = ir_q[5:0];
   assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
   assign pc_plus4 = pc_q + 32'd4;
   assign jmp_tgt  = {pc_plus4[31:28], ir_q[25:0], 2'b00};

   logic is_rtype, is_alu_r, is_jr, is_lw, is_sw, is_beq, is_j, is_jal, is_addi, legal;

   assign is_rtype = (op == OP_RTYPE);
   assign is_alu_r = is_rtype && ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                                  (funct == FN_OR)  || (funct == FN_SLT));
   assign is_jr    = is_rtype && (funct == FN_JR);
   assign is_lw    = (op == OP_LW);
   assign is_sw    = (op == OP_SW);
   assign is_beq   = (op == OP_BEQ);
   assign is_j     = (op == OP_J);
   assign is_jal   = (op == OP_JAL);
`ifdef MULTICYCLE_ADDI_EN
   assign is_addi  = (op == OP_ADDI);
`else
   assign is_addi  = 1'b0;
`endif
   assign legal    = is_alu_r || is_jr || is_lw || is_sw || is_beq || is_j || is_jal || is_addi;

   // Shared ALU: R-type ops on the two operands, otherwise rs + sext(imm)
   logic [31:0] alu_b;
   logic [31:0] alu_res;

   assign alu_b = is_rtype ? opb_q : sext_imm;

   always_comb begin
      alu_res = opa_q + alu_b;
      if (is_rtype) begin
         case (funct)
            FN_SUB:  alu_res = opa_q - alu_b;
            FN_AND:  alu_res = opa_q & alu_b;
            FN_OR:   alu_res = opa_q | alu_b;
            FN_SLT:  alu_res = {31'd0, $signed(opa_q) < $signed(alu_b)};
            default: alu_res = opa_q + alu_b;
         endcase
      end
   end

   logic [4:0]  wb_idx;
   logic [31:0] wb_val;

   assign wb_idx = is_rtype ? rd : rt;
   assign wb_val = is_lw ? mdr_q : res_q;

   // Sequencer: every output register is updated on the edge that enters the state it belongs to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         ir_q       <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         br_tgt_q   <= '0;
         res_q      <= '0;
         mdr_q      <= '0;
         ir_req_q   <= 1'b0;
         cen_q      <= 1'b1;
         wen_q      <= 1'b1;
         a_q        <= '0;
         rd2_q      <= '0;
         rf_wdata_q <= '0;
         rf_we_q    <= 1'b0;
         trap_q     <= 1'b0;
         for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         rf_we_q <= 1'b0;
         case (state_q)
            S_FETCH: begin
               ir_req_q <= 1'b1;
               if (ir_req_q && bus.IR_valid) begin
                  ir_q     <= bus.IR;
                  ir_req_q <= 1'b0;
                  state_q  <= S_DECODE;
               end
            end
            S_DECODE: begin
               opa_q    <= rf_q[rs];
               opb_q    <= rf_q[rt];
               br_tgt_q <= pc_plus4 + (sext_imm << 2);
               if (legal) begin
                  state_q <= S_EXEC;
               end else begin
                  trap_q  <= 1'b1;
                  state_q <= S_TRAP;
               end
            end
            S_EXEC: begin
               if (is_alu_r || is_addi) begin
                  res_q   <= alu_res;
                  state_q <= S_WB;
               end else if (is_lw || is_sw) begin
                  a_q     <= alu_res[DATA_AW+1:2];
                  rd2_q   <= opb_q;
                  cen_q   <= 1'b0;
                  wen_q   <= ~is_sw;
                  state_q <= S_MEM;
               end else begin
                  if (is_beq) begin
                     pc_q <= (opa_q == opb_q) ? br_tgt_q : pc_plus4;
                  end else if (is_j || is_jal) begin
                     pc_q <= jmp_tgt;
                  end else begin
                     pc_q <= opa_q;
                  end
                  if (is_jal) begin
                     rf_q[RA_IDX] <= pc_plus4;
                     rf_wdata_q   <= pc_plus4;
                     rf_we_q      <= 1'b1;
                  end
                  ir_req_q <= 1'b1;
                  state_q  <= S_FETCH;
               end
            end
            S_MEM: begin
               if (bus.mem_ready) begin
                  cen_q <= 1'b1;
                  wen_q <= 1'b1;
                  if (is_sw) begin
                     pc_q     <= pc_plus4;
                     ir_req_q <= 1'b1;
                     state_q  <= S_FETCH;
                  end else begin
                     mdr_q   <= bus.ReadDataMem;
                     state_q <= S_WB;
                  end
               end
            end
            S_WB: begin
               // $0 stays hard-wired: the commit still pulses RF_we but the array is untouched
               if (wb_idx != 5'd0) rf_q[wb_idx] <= wb_val;
               rf_wdata_q <= wb_val;
               rf_we_q    <= 1'b1;
               pc_q       <= pc_plus4;
               ir_req_q   <= 1'b1;
               state_q    <= S_FETCH;
            end
            S_TRAP: begin
               state_q <= S_TRAP;
            end
            default: begin
               trap_q   <= 1'b1;
               ir_req_q <= 1'b0;
               cen_q    <= 1'b1;
               wen_q    <= 1'b1;
               state_q  <= S_TRAP;
            end
         endcase
      end
   end

   assign bus.IR_addr      = pc_q;
   assign bus.IR_req       = ir_req_q;
   assign bus.CEN          = cen_q;
   assign bus.WEN          = wen_q;
   assign bus.OEN          = 1'b0;
   assign bus.A            = a_q;
   assign bus.ReadData2    = rd2_q;
   assign bus.RF_writedata = rf_wdata_q;
   assign bus.RF_we        = rf_we_q;
   assign bus.trap         = trap_q;

endmodule

// File: tb/tb_multicycle_mips.sv
// Randomized bench for multicycle_mips: acts as instruction/data memory and checks against an ISA-level model.
module tb_multicycle_mips;
   localparam int unsigned DATA_AW    = 7;
   localparam int unsigned DMEM_WORDS = 1 << DATA_AW;
   localparam logic [31:0] RESET_PC   = 32'h0;

   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_JR   = 6'h08;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   multicycle_mips_if #(.DATA_AW(DATA_AW)) bus ();

   multicycle_mips #(.DATA_AW(DATA_AW), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Architectural model state; dmem is also the memory the bench serves to the core
   logic [31:0] m_rf [32];
   logic [31:0] dmem [DMEM_WORDS];
   logic [31:0] m_pc;
   logic [31:0] m_last_wd;
   int          n_checks;
   int          n_pass;

   // Prediction for the instruction in flight
   logic [31:0]        e_npc, e_wd, e_rd2, e_ld;
   logic [4:0]         e_widx;
   logic [DATA_AW-1:0] e_a;
   bit                 e_we, e_trap, e_mem, e_sw;
   int                 e_cyc;

   task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
      return {op, idx};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_pc      = RESET_PC;
      m_last_wd = 32'd0;
   endtask

   // ISA semantics: what the instruction does and how many cycles it costs without stalls
   task automatic predict(input logic [31:0] instr);
      logic [5:0]  op, fn;
      logic [31:0] a, b, simm, pc4, addr;
      op   = instr[31:26];
      fn   = instr[5:0];
      a    = m_rf[instr[25:21]];
      b    = m_rf[instr[20:16]];
      simm = {{16{instr[15]}}, instr[15:0]};
      pc4  = m_pc + 32'd4;
      addr = a + simm;
      e_npc = pc4; e_wd = m_last_wd; e_widx = 5'd0; e_rd2 = b; e_ld = 32'd0;
      e_a = addr[DATA_AW+1:2];
      e_we = 1'b0; e_trap = 1'b0; e_mem = 1'b0; e_sw = 1'b0; e_cyc = 4;
      case (op)
         6'h00: begin
            e_we = 1'b1; e_widx = instr[15:11];
            case (fn)
               FN_ADD: e_wd = a + b;
               FN_SUB: e_wd = a - b;
               FN_AND: e_wd = a & b;
               FN_OR:  e_wd = a | b;
               FN_SLT: e_wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               FN_JR:  begin e_we = 1'b0; e_wd = m_last_wd; e_npc = a; e_cyc = 3; end
               default: begin e_we = 1'b0; e_wd = m_last_wd; e_trap = 1'b1; e_cyc = 2; end
            endcase
         end
         OP_LW:  begin e_mem = 1'b1; e_ld = dmem[e_a]; e_we = 1'b1; e_wd = e_ld;
                       e_widx = instr[20:16]; e_cyc = 5; end
         OP_SW:  begin e_mem = 1'b1; e_sw = 1'b1; e_cyc = 4; end
         OP_BEQ: begin e_npc = (a == b) ? pc4 + (simm << 2) : pc4; e_cyc = 3; end
         OP_J:   begin e_npc = {pc4[31:28], instr[25:0], 2'b00}; e_cyc = 3; end
         OP_JAL: begin e_npc = {pc4[31:28], instr[25:0], 2'b00}; e_cyc = 3;
                       e_we = 1'b1; e_wd = pc4; e_widx = 5'd31; end
`ifdef MULTICYCLE_ADDI_EN
         OP_ADDI: begin e_we = 1'b1; e_wd = a + simm; e_widx = instr[20:16]; e_cyc = 4; end
`endif
         default: begin e_trap = 1'b1; e_cyc = 2; end
      endcase
   endtask

   task automatic commit();
      if (e_we) begin
         m_rf[e_widx] = e_wd;
         m_last_wd    = e_wd;
      end
      m_rf[0] = 32'd0;
      if (e_mem && e_sw) dmem[e_a] = e_rd2;
      m_pc = e_npc;
   endtask

   // Asserts reset between clock edges and checks that every output takes its reset value at once
   task automatic do_reset();
      rst_n = 1'b0;
      bus.IR_valid  = 1'b0;
      bus.mem_ready = 1'b0;
      #1;
      check32("rst_trap",    32'(bus.trap),    32'd0);
      check32("rst_ir_addr", bus.IR_addr,      RESET_PC);
      check32("rst_ir_req",  32'(bus.IR_req),  32'd0);
      check32("rst_cen",     32'(bus.CEN),     32'd1);
      check32("rst_wen",     32'(bus.WEN),     32'd1);
      check32("rst_oen",     32'(bus.OEN),     32'd0);
      check32("rst_a",       32'(bus.A),       32'd0);
      check32("rst_rd2",     bus.ReadData2,    32'd0);
      check32("rst_wdata",   bus.RF_writedata, 32'd0);
      check32("rst_we",      32'(bus.RF_we),   32'd0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check32("post_rst_ir_req", 32'(bus.IR_req), 32'd1);
   endtask

   // Serves one instruction to the core and checks its whole execution against the model
   task automatic exec_instr(input logic [31:0] instr, input int iv_stall, input int mem_stall,
                             input bit abort_mem);
      int n, w, we_cnt, mem_cyc, exp_n;
      predict(instr);
      w = 0;
      while (!bus.IR_req && w < 20) begin
         @(negedge clk);
         w++;
      end
      check32("fetch_req", 32'(bus.IR_req), 32'd1);
      check32("fetch_pc",  bus.IR_addr,     m_pc);
      n = 0; we_cnt = 0; mem_cyc = 0;
      for (int s = 0; s < iv_stall; s++) begin
         bus.IR_valid  = 1'b0;
         bus.IR        = $urandom;
         bus.mem_ready = 1'($urandom);
         @(negedge clk);
         n++;
         we_cnt += int'(bus.RF_we);
         check32("stall_ir_req", 32'(bus.IR_req), 32'd1);
      end
      bus.IR_valid = 1'b1;
      bus.IR       = instr;
      @(negedge clk);
      n++;
      while (!bus.IR_req && !bus.trap && n < 40) begin
         bus.IR_valid = 1'($urandom);
         bus.IR       = $urandom;
         we_cnt += int'(bus.RF_we);
         if (!bus.CEN) begin
            if (abort_mem) begin
               #2;
               do_reset();
               return;
            end
            check32("mem_a",   32'(bus.A),   32'(e_a));
            check32("mem_wen", 32'(bus.WEN), e_sw ? 32'd0 : 32'd1);
            if (e_sw) check32("mem_wdata", bus.ReadData2, e_rd2);
            bus.mem_ready   = (mem_cyc >= mem_stall);
            bus.ReadDataMem = e_ld;
            mem_cyc++;
         end else begin
            bus.mem_ready   = 1'($urandom);
            bus.ReadDataMem = $urandom;
         end
         @(negedge clk);
         n++;
      end
      we_cnt += int'(bus.RF_we);
      exp_n = e_cyc + iv_stall + (e_mem ? mem_stall : 0);
      check32("cycles",   32'(n),       32'(exp_n));
      check32("mem_cyc",  32'(mem_cyc), e_mem ? 32'(mem_stall + 1) : 32'd0);
      check32("trap",     32'(bus.trap), 32'(e_trap));
      check32("we_pulse", 32'(we_cnt),  32'(e_we));
      commit();
      check32("wdata", bus.RF_writedata, m_last_wd);
      if (e_trap) begin
         bus.IR_valid  = 1'b1;
         bus.mem_ready = 1'b1;
         repeat (4) @(negedge clk);
         check32("trap_hold",   32'(bus.trap),   32'd1);
         check32("trap_ir_req", 32'(bus.IR_req), 32'd0);
         check32("trap_cen",    32'(bus.CEN),    32'd1);
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0]  fns [5];
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      int          k;
      fns[0] = FN_ADD; fns[1] = FN_SUB; fns[2] = FN_AND; fns[3] = FN_OR; fns[4] = FN_SLT;
      rs  = 5'($urandom);
      rt  = 5'($urandom);
      rd  = 5'($urandom);
      imm = 16'($urandom);
      k   = int'($urandom_range(0, 10));
      case (k)
         0, 1, 2, 3: return enc_r(rs, rt, rd, fns[$urandom_range(0, 4)]);
         4, 5:       return enc_i(OP_LW, rs, rt, imm);
         6:          return enc_i(OP_SW, rs, rt, imm);
         7:          return enc_i(OP_BEQ, rs, rt, 16'($urandom_range(0, 15)) - 16'd8);
         8:          return enc_j(($urandom_range(0, 1) == 0) ? OP_J : OP_JAL, 26'($urandom));
         9:          return enc_r(rs, 5'd0, 5'd0, FN_JR);
`ifdef MULTICYCLE_ADDI_EN
         default:    return enc_i(OP_ADDI, rs, rt, imm);
`else
         default:    return enc_r(rs, rt, rd, FN_ADD);
`endif
      endcase
   endfunction

   initial begin
      n_checks = 0;
      n_pass   = 0;
      bus.IR          = '0;
      bus.IR_valid    = 1'b0;
      bus.ReadDataMem = '0;
      bus.mem_ready   = 1'b0;
      for (int i = 0; i < int'(DMEM_WORDS); i++) dmem[i] = $urandom;
      dmem[0] = 32'd5;
      dmem[1] = 32'd3;
      model_reset();
      #3;
      do_reset();

      exec_instr(enc_i(OP_LW, 5'd0, 5'd1, 16'd0), 0, 0, 1'b0);
      exec_instr(enc_i(OP_LW, 5'd0, 5'd2, 16'd4), 0, 0, 1'b0);
      exec_instr(enc_r(5'd1, 5'd2, 5'd3, FN_ADD), 0, 0, 1'b0);
      check32("tp_add", bus.RF_writedata, 32'd8);
      exec_instr(enc_r(5'd2, 5'd1, 5'd4, FN_SLT), 0, 0, 1'b0);
      check32("tp_slt", bus.RF_writedata, 32'd1);
      exec_instr(enc_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFF), 0, 0, 1'b0);
      check32("tp_beq_pc", bus.IR_addr, 32'h10);
      exec_instr(enc_r(5'd2, 5'd1, 5'd5, FN_SUB), 0, 0, 1'b0);
      check32("tp_sub", bus.RF_writedata, 32'hFFFF_FFFE);
      exec_instr(enc_i(OP_SW, 5'd0, 5'd3, 16'd8), 0, 3, 1'b0);
      exec_instr(enc_i(OP_LW, 5'd0, 5'd6, 16'd8), 0, 3, 1'b0);
      check32("tp_lw", bus.RF_writedata, 32'd8);
      exec_instr(enc_r(5'd1, 5'd2, 5'd0, FN_ADD), 5, 0, 1'b0);
      exec_instr(enc_j(OP_JAL, 26'h40), 0, 0, 1'b0);
      check32("tp_jal_pc", bus.IR_addr, 32'h100);
      check32("tp_jal_ra", bus.RF_writedata, 32'h24);
      exec_instr(enc_r(5'd31, 5'd0, 5'd0, FN_JR), 0, 0, 1'b0);
      check32("tp_jr_pc", bus.IR_addr, 32'h24);
      exec_instr(enc_r(5'd0, 5'd1, 5'd8, FN_ADD), 0, 0, 1'b0);
      check32("tp_zero_reg", bus.RF_writedata, 32'd5);

      for (int t = 0; t < 150; t++) begin
         exec_instr(rand_instr(),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0,
                    1'b0);
      end

      // Reset in the middle of a stalled store: nothing may commit
      exec_instr(enc_i(OP_SW, 5'd0, 5'd0, 16'd12), 0, 6, 1'b1);
      exec_instr(enc_i(OP_LW, 5'd0, 5'd9, 16'd12), 0, 1, 1'b0);

      exec_instr(32'hFC00_0000, 0, 0, 1'b0);
      @(negedge clk);
      #2;
      do_reset();

      exec_instr(enc_i(OP_ADDI, 5'd0, 5'd7, 16'hFFFE), 1, 0, 1'b0);
`ifdef MULTICYCLE_ADDI_EN
      check32("tp_addi", bus.RF_writedata, 32'hFFFF_FFFE);
      exec_instr(enc_r(5'd7, 5'd0, 5'd10, FN_OR), 0, 0, 1'b0);
`else
      check32("tp_addi_trap", 32'(bus.trap), 32'd1);
      @(negedge clk);
      #2;
      do_reset();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
